// File: rtl/keccak_rc_lfsr_gen.sv
// Keccak-f[1600] iota round-constant generator driven by the rc(t) LFSR.
// Emits NUM_ROUNDS constants per start on a valid/ready handshake, tagged with ROM-style indices.
module keccak_rc_lfsr_gen #(
  parameter int unsigned NUM_ROUNDS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rc_ready,
  output logic        rc_valid,
  output logic [63:0] rc_out,
  output logic [4:0]  round_index,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_e;

  localparam logic [4:0] LAST_IR = 5'(NUM_ROUNDS - 1);

  state_e      state_q;
  logic [7:0]  lfsr_q;
  logic [2:0]  j_q;
  logic [4:0]  ir_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [63:0] rc_q;
  logic [4:0]  idx_q;
  logic        valid_q;
  logic        done_q;

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    lfsr_step = {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
  endfunction

  // rc bit j of a round lands at bit position 2^j - 1
  function automatic logic [5:0] bit_pos(input logic [2:0] j);
    case (j)
      3'd0:    bit_pos = 6'd0;
      3'd1:    bit_pos = 6'd1;
      3'd2:    bit_pos = 6'd3;
      3'd3:    bit_pos = 6'd7;
      3'd4:    bit_pos = 6'd15;
      3'd5:    bit_pos = 6'd31;
      default: bit_pos = 6'd63;
    endcase
  endfunction

  always_comb begin
    acc_d = acc_q;
    acc_d[bit_pos(j_q)] = lfsr_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= 8'h01;
      j_q     <= 3'd0;
      ir_q    <= 5'd0;
      acc_q   <= 64'd0;
      rc_q    <= 64'd0;
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= GEN;
            lfsr_q  <= 8'h01;
            j_q     <= 3'd0;
            ir_q    <= 5'd0;
            acc_q   <= 64'd0;
          end
        end
        GEN: begin
          acc_q  <= acc_d;
          lfsr_q <= lfsr_step(lfsr_q);
          j_q    <= j_q + 3'd1;
          if (j_q == 3'd6) begin
            state_q <= HOLD;
            rc_q    <= acc_d;
            idx_q   <= ir_q + 5'd1;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          // LFSR keeps running across rounds; only the accumulator restarts
          if (valid_q && rc_ready) begin
            valid_q <= 1'b0;
            if (ir_q == LAST_IR) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= GEN;
              ir_q    <= ir_q + 5'd1;
              j_q     <= 3'd0;
              acc_q   <= 64'd0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rc_valid    = valid_q;
  assign rc_out      = rc_q;
  assign round_index = idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_keccak_rc_lfsr_gen.sv
// Directed table-driven bench for keccak_rc_lfsr_gen (24-round build plus a 1-round build).
module tb_keccak_rc_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset, start, rc_ready;
  logic        rc_valid, busy, done;
  logic [63:0] rc_out;
  logic [4:0]  round_index;

  logic        start1, rc_ready1;
  logic        rc_valid1, busy1, done1;
  logic [63:0] rc_out1;
  logic [4:0]  round_index1;

  always #5 clk = ~clk;

  keccak_rc_lfsr_gen #(.NUM_ROUNDS(24)) dut (
    .clk(clk), .reset(reset), .start(start), .rc_ready(rc_ready),
    .rc_valid(rc_valid), .rc_out(rc_out), .round_index(round_index),
    .busy(busy), .done(done)
  );

  keccak_rc_lfsr_gen #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rc_ready(rc_ready1),
    .rc_valid(rc_valid1), .rc_out(rc_out1), .round_index(round_index1),
    .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [63:0] rc;
    logic [4:0]  idx;
    int          stall;
  } vec_t;

  vec_t tbl[24];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit rnd, output int n);
    n = 0;
    while (!rc_valid && n < 20) begin
      if (rnd) start = 1'($urandom_range(0, 1));
      step();
      n++;
    end
  endtask

  task automatic run_seq(input bit use_stall, input bit rnd);
    int n, tot, exp_tot;
    exp_tot = 24 * 8;
    start = 1'b1;
    step();
    start = 1'b0;
    tot = 0;
    for (int k = 0; k < 24; k++) begin
      wait_valid(rnd, n);
      tot += n;
      chk($sformatf("latency r%0d", k), 64'(n), 64'd7);
      chk($sformatf("rc_out r%0d", k), rc_out, tbl[k].rc);
      chk($sformatf("index r%0d", k), 64'(round_index), 64'(tbl[k].idx));
      chk($sformatf("busy r%0d", k), 64'(busy), 64'd1);
      if (use_stall && tbl[k].stall > 0) begin
        exp_tot += tbl[k].stall;
        rc_ready = 1'b0;
        for (int s = 0; s < tbl[k].stall; s++) begin
          if (rnd) start = 1'($urandom_range(0, 1));
          step();
          tot++;
          chk($sformatf("stall valid r%0d", k), 64'(rc_valid), 64'd1);
          chk($sformatf("stall rc r%0d", k), rc_out, tbl[k].rc);
          chk($sformatf("stall idx r%0d", k), 64'(round_index), 64'(tbl[k].idx));
        end
        rc_ready = 1'b1;
      end
      // start on the final handshake edge must be ignored
      if (k == 23) start = 1'b1;
      step();
      tot++;
      start = 1'b0;
      if (k < 23) chk($sformatf("valid drop r%0d", k), 64'(rc_valid), 64'd0);
    end
    chk("done pulse", 64'(done), 64'd1);
    chk("busy at done", 64'(busy), 64'd0);
    chk("valid at done", 64'(rc_valid), 64'd0);
    chk("total cycles", 64'(tot), 64'(exp_tot));
    step();
    chk("done one cycle", 64'(done), 64'd0);
    chk("no restart", 64'(busy), 64'd0);
    chk("rc held after done", rc_out, 64'h8000_0000_8000_8008);
  endtask

  initial begin
    int n;
    tbl[0]  = '{64'h0000_0000_0000_0001, 5'd1,  3};
    tbl[1]  = '{64'h0000_0000_0000_8082, 5'd2,  0};
    tbl[2]  = '{64'h8000_0000_0000_808A, 5'd3,  0};
    tbl[3]  = '{64'h8000_0000_8000_8000, 5'd4,  0};
    tbl[4]  = '{64'h0000_0000_0000_808B, 5'd5,  10};
    tbl[5]  = '{64'h0000_0000_8000_0001, 5'd6,  0};
    tbl[6]  = '{64'h8000_0000_8000_8081, 5'd7,  0};
    tbl[7]  = '{64'h8000_0000_0000_8009, 5'd8,  0};
    tbl[8]  = '{64'h0000_0000_0000_008A, 5'd9,  0};
    tbl[9]  = '{64'h0000_0000_0000_0088, 5'd10, 0};
    tbl[10] = '{64'h0000_0000_8000_8009, 5'd11, 0};
    tbl[11] = '{64'h0000_0000_8000_000A, 5'd12, 0};
    tbl[12] = '{64'h0000_0000_8000_808B, 5'd13, 0};
    tbl[13] = '{64'h8000_0000_0000_008B, 5'd14, 0};
    tbl[14] = '{64'h8000_0000_0000_8089, 5'd15, 0};
    tbl[15] = '{64'h8000_0000_0000_8003, 5'd16, 0};
    tbl[16] = '{64'h8000_0000_0000_8002, 5'd17, 0};
    tbl[17] = '{64'h8000_0000_0000_0080, 5'd18, 0};
    tbl[18] = '{64'h0000_0000_0000_800A, 5'd19, 0};
    tbl[19] = '{64'h8000_0000_8000_000A, 5'd20, 0};
    tbl[20] = '{64'h8000_0000_8000_8081, 5'd21, 0};
    tbl[21] = '{64'h8000_0000_0000_8080, 5'd22, 0};
    tbl[22] = '{64'h0000_0000_8000_0001, 5'd23, 0};
    tbl[23] = '{64'h8000_0000_8000_8008, 5'd24, 0};

    reset = 1'b1; start = 1'b0; rc_ready = 1'b1;
    start1 = 1'b0; rc_ready1 = 1'b1;
    step();
    step();
    chk("reset valid", 64'(rc_valid), 64'd0);
    chk("reset rc", rc_out, 64'd0);
    chk("reset idx", 64'(round_index), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    step();

    run_seq(1'b0, 1'b1);
    run_seq(1'b1, 1'b0);

    // reset in the middle of round 10 generation
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wait_valid(1'b0, n);
      step();
    end
    step();
    step();
    step();
    chk("mid busy before reset", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    chk("abort valid", 64'(rc_valid), 64'd0);
    chk("abort rc", rc_out, 64'd0);
    chk("abort idx", 64'(round_index), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    reset = 1'b0;
    step();
    chk("no done after abort", 64'(done), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(1'b0, n);
    chk("restart latency", 64'(n), 64'd7);
    chk("restart rc", rc_out, 64'h1);
    chk("restart idx", 64'(round_index), 64'd1);

    // single-round build
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 0;
    while (!rc_valid1 && n < 20) begin
      step();
      n++;
    end
    chk("nr1 latency", 64'(n), 64'd7);
    chk("nr1 rc", rc_out1, 64'h1);
    chk("nr1 idx", 64'(round_index1), 64'd1);
    step();
    chk("nr1 done", 64'(done1), 64'd1);
    chk("nr1 busy", 64'(busy1), 64'd0);
    chk("nr1 valid", 64'(rc_valid1), 64'd0);
    step();
    chk("nr1 done cleared", 64'(done1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
